load_sequencer_rr: RTL

- Round-robin scheduler that shares the single ROM-to-FIFO loader between two requesters, e.g. sensor-init and calibration tables.
- Latches the winning requester's ROM base address and load count, and pulses the loader's start.
- Waits for the loader's done, then returns a one-cycle ack, or an error on watchdog timeout.
- Sits between the control FSMs and the loader.

---
 rtl/load_sequencer_rr.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/load_sequencer_rr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : load_sequencer_rr
// Purpose  : Round-robin scheduler that shares one ROM-to-FIFO loader between
//            two requesters. It latches the winner's ROM base address and
//            word count, pulses the loader start, then waits for done. It
//            returns a one-cycle ack on completion, or a one-cycle err on a
//            zero count or a watchdog timeout (the loader is aborted first).
// Revision : 1.0 - initial release
// ============================================================================
module load_sequencer_rr #(
  parameter int ADDR_W  = 8,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] base_addr0,
  input  logic [CNT_W-1:0]  n_loads0,
  input  logic [ADDR_W-1:0] base_addr1,
  input  logic [CNT_W-1:0]  n_loads1,
  output logic [1:0]        ack,
  output logic [1:0]        err,
  output logic              busy,
  output logic              grant_id,
  output logic              ld_start,
  output logic [ADDR_W-1:0] ld_base_addr,
  output logic [CNT_W-1:0]  ld_n_loads,
  output logic              ld_abort,
  input  logic              ld_done
);

  // Watchdog counter is a fixed 10 bits; TIMEOUT must lie in 1..1023.
  localparam int             c_tmo_w   = 10;
  localparam logic [c_tmo_w-1:0] c_timeout = c_tmo_w'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_WAIT  = 3'd2,
    S_ACK   = 3'd3,
    S_ABORT = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t               r_state;
  logic                 r_ptr;     // preferred requester when both request
  logic [c_tmo_w-1:0]   r_cnt;     // cycles spent in WAIT

  logic                 w_pick;    // arbitration winner in IDLE
  logic [1:0]           w_grant_oh;
  logic [c_tmo_w-1:0]   w_cnt_inc;
  logic                 w_cnt_expire;

  // Winner selection, one-hot of the current grantee, and watchdog next-value.
  always_comb begin
    w_pick       = (req == 2'b11) ? r_ptr : req[1];
    w_grant_oh   = grant_id ? 2'b10 : 2'b01;
    w_cnt_inc    = r_cnt + c_tmo_w'(1);
    // The second term only guards against an already-saturated counter.
    w_cnt_expire = (w_cnt_inc == c_timeout) || (r_cnt == c_timeout);
  end

  // Sequencer FSM: every output is a register written alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_ptr        <= 1'b0;
      r_cnt        <= '0;
      ack          <= 2'b00;
      err          <= 2'b00;
      busy         <= 1'b0;
      grant_id     <= 1'b0;
      ld_start     <= 1'b0;
      ld_abort     <= 1'b0;
      ld_base_addr <= '0;
      ld_n_loads   <= '0;
    end else begin
      // Pulse outputs default low so each is high for exactly one cycle.
      ack      <= 2'b00;
      err      <= 2'b00;
      ld_start <= 1'b0;
      ld_abort <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (req != 2'b00) begin
            grant_id     <= w_pick;
            ld_base_addr <= w_pick ? base_addr1 : base_addr0;
            ld_n_loads   <= w_pick ? n_loads1   : n_loads0;
            busy         <= 1'b1;
            r_state      <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (ld_n_loads == '0) begin
            // Nothing to load: report an error without touching the loader.
            err     <= w_grant_oh;
            r_ptr   <= ~grant_id;
            r_state <= S_ERR;
          end else begin
            ld_start <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_WAIT;
          end
        end

        S_WAIT: begin
          // A done on the very cycle the watchdog expires still completes.
          if (ld_done) begin
            ack     <= w_grant_oh;
            r_ptr   <= ~grant_id;
            r_state <= S_ACK;
          end else begin
            if (r_cnt != c_timeout) begin
              r_cnt <= w_cnt_inc;
            end
            if (w_cnt_expire) begin
              ld_abort <= 1'b1;
              r_state  <= S_ABORT;
            end
          end
        end

        S_ACK: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        S_ABORT: begin
          err     <= w_grant_oh;
          r_ptr   <= ~grant_id;
          r_state <= S_ERR;
        end

        S_ERR: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
